// File: rtl/game_pkg.sv
// Shared types and width helper for the turn controller.
package game_pkg;

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT, S_RAND, S_CHECK, S_COMMIT, S_WINCHK, S_NEXT, S_DONE
  } state_t;

  // Bits needed to hold values 0..n-1, never less than one.
  function automatic int width_of(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/turn_timer.sv
// Per-turn countdown: loads a fixed value, counts down while enabled, saturates at 0.
module turn_timer #(
  parameter int W        = 8,
  parameter int LOAD_VAL = 250
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         en,
  output logic [W-1:0] count,
  output logic         zero
);

  always_ff @(posedge clk) begin
    if (rst)                     count <= '0;
    else if (load)               count <= W'(LOAD_VAL);
    else if (en && count != '0)  count <= count - W'(1);
  end

  assign zero = (count == '0);

endmodule

// File: rtl/game_turn_ctrl.sv
// Turn sequencer: player move or timeout-forced random move, validation, commit, win check.
module game_turn_ctrl
  import game_pkg::*;
#(
  parameter  int NUM_PLAYERS    = 2,
  parameter  int TIMEOUT_CYCLES = 250,
  parameter  int MAX_MOVES      = 9,
  localparam int PW             = width_of(NUM_PLAYERS),
  localparam int TW             = width_of(TIMEOUT_CYCLES + 1),
  localparam int MW             = width_of(MAX_MOVES + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          move_ready,
  input  logic          chk_done,
  input  logic          chk_ok,
  input  logic          rand_done,
  input  logic          win_done,
  input  logic          win,
  output logic [PW-1:0] player,
  output logic [TW-1:0] time_left,
  output logic [MW-1:0] move_count,
  output logic          chk_req,
  output logic          rand_req,
  output logic          win_req,
  output logic          commit,
  output logic          game_over,
  output logic          tie
);

  state_t state, state_n;
  logic   tmr_load, tmr_en, tmr_zero;
  logic   board_full;

  assign board_full = (move_count == MW'(MAX_MOVES));

  turn_timer #(.W(TW), .LOAD_VAL(TIMEOUT_CYCLES)) u_timer (
    .clk   (clk),
    .rst   (rst),
    .load  (tmr_load),
    .en    (tmr_en),
    .count (time_left),
    .zero  (tmr_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n  = state;
    tmr_load = 1'b0;
    tmr_en   = 1'b0;
    case (state)
      S_IDLE, S_DONE: if (start) begin
        state_n  = S_WAIT;
        tmr_load = 1'b1;
      end
      // A committed move wins over an expiring timer; the timer freezes while checking.
      S_WAIT: begin
        if (move_ready)    state_n = S_CHECK;
        else if (tmr_zero) state_n = S_RAND;
        else               tmr_en  = 1'b1;
      end
      S_CHECK:  if (chk_done)  state_n = chk_ok ? S_COMMIT : S_WAIT;
      S_RAND:   if (rand_done) state_n = S_COMMIT;
      S_COMMIT: state_n = S_WINCHK;
      S_WINCHK: if (win_done)  state_n = (win || board_full) ? S_DONE : S_NEXT;
      S_NEXT: begin
        state_n  = S_WAIT;
        tmr_load = 1'b1;
      end
      default:  state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      player     <= '0;
      move_count <= '0;
      tie        <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: if (start) begin
          player     <= '0;
          move_count <= '0;
          tie        <= 1'b0;
        end
        S_COMMIT: move_count <= move_count + MW'(1);
        S_WINCHK: if (win_done && !win && board_full) tie <= 1'b1;
        S_NEXT:   player <= (player == PW'(NUM_PLAYERS - 1)) ? '0 : player + PW'(1);
        default: ;
      endcase
    end
  end

  assign chk_req   = (state == S_CHECK);
  assign rand_req  = (state == S_RAND);
  assign win_req   = (state == S_WINCHK);
  assign commit    = (state == S_COMMIT);
  assign game_over = (state == S_DONE);

endmodule

// File: tb/tb_game_turn_ctrl.sv
// Directed bench: a 3-player and a 2-player controller run on shared stimulus in lockstep.
module tb_game_turn_ctrl;

  logic clk = 1'b0;
  logic rst, start, move_ready, chk_done, chk_ok, rand_done, win_done, win;

  logic [1:0] player_a;
  logic [0:0] player_b;
  logic [2:0] tl_a, tl_b;
  logic [3:0] mc_a, mc_b;
  logic chk_req_a, rand_req_a, win_req_a, commit_a, over_a, tie_a;
  logic chk_req_b, rand_req_b, win_req_b, commit_b, over_b, tie_b;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  game_turn_ctrl #(.NUM_PLAYERS(3), .TIMEOUT_CYCLES(4), .MAX_MOVES(9)) u_dut_a (
    .clk(clk), .rst(rst), .start(start), .move_ready(move_ready),
    .chk_done(chk_done), .chk_ok(chk_ok), .rand_done(rand_done),
    .win_done(win_done), .win(win),
    .player(player_a), .time_left(tl_a), .move_count(mc_a),
    .chk_req(chk_req_a), .rand_req(rand_req_a), .win_req(win_req_a),
    .commit(commit_a), .game_over(over_a), .tie(tie_a)
  );

  game_turn_ctrl #(.NUM_PLAYERS(2), .TIMEOUT_CYCLES(4), .MAX_MOVES(9)) u_dut_b (
    .clk(clk), .rst(rst), .start(start), .move_ready(move_ready),
    .chk_done(chk_done), .chk_ok(chk_ok), .rand_done(rand_done),
    .win_done(win_done), .win(win),
    .player(player_b), .time_left(tl_b), .move_count(mc_b),
    .chk_req(chk_req_b), .rand_req(rand_req_b), .win_req(win_req_b),
    .commit(commit_b), .game_over(over_b), .tie(tie_b)
  );

  task automatic check(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One accepted player move from WAIT; ends back in WAIT unless the game finishes.
  task automatic do_move(input bit w, input bit fin);
    move_ready = 1'b1; tick(); move_ready = 1'b0;
    check("chk_req", int'(chk_req_a), 1);
    chk_done = 1'b1; chk_ok = 1'b1; tick(); chk_done = 1'b0; chk_ok = 1'b0;
    check("chk_req_drop", int'(chk_req_a), 0);
    check("commit", int'(commit_a), 1);
    tick();
    check("commit_once", int'(commit_a), 0);
    check("win_req", int'(win_req_a), 1);
    win_done = 1'b1; win = w; tick(); win_done = 1'b0; win = 1'b0;
    check("win_req_drop", int'(win_req_a), 0);
    if (!(w || fin)) begin
      tick();
      check("tl_reload", int'(tl_a), 4);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; move_ready = 1'b0; chk_done = 1'b0; chk_ok = 1'b0;
    rand_done = 1'b0; win_done = 1'b0; win = 1'b0;
    tick(); tick();
    check("rst_player", int'(player_a), 0);
    check("rst_time_left", int'(tl_a), 0);
    check("rst_move_count", int'(mc_a), 0);
    check("rst_tie", int'(tie_a), 0);
    check("rst_req_or", int'(chk_req_a | rand_req_a | win_req_a | commit_a | over_a), 0);
    rst = 1'b0;

    // three-player rotation
    start = 1'b1; tick(); start = 1'b0;
    check("start_tl", int'(tl_a), 4);
    check("start_player", int'(player_a), 0);
    do_move(1'b0, 1'b0); check("rot1_a", int'(player_a), 1); check("rot1_b", int'(player_b), 1);
    do_move(1'b0, 1'b0); check("rot2_a", int'(player_a), 2); check("rot2_b", int'(player_b), 0);
    do_move(1'b0, 1'b0); check("rot3_a", int'(player_a), 0); check("rot3_b", int'(player_b), 1);
    check("mc_after3", int'(mc_a), 3);

    // rejected move keeps remaining time; start ignored mid-turn
    tick(); tick();
    check("tl_before_rej", int'(tl_a), 2);
    move_ready = 1'b1; tick(); move_ready = 1'b0;
    check("rej_chk_req", int'(chk_req_a), 1);
    check("rej_tl_frozen", int'(tl_a), 2);
    start = 1'b1; chk_done = 1'b1; chk_ok = 1'b0; tick();
    start = 1'b0; chk_done = 1'b0;
    check("rej_chk_drop", int'(chk_req_a), 0);
    check("rej_no_commit", int'(commit_a), 0);
    check("rej_tl_kept", int'(tl_a), 2);
    check("rej_mc", int'(mc_a), 3);
    do_move(1'b0, 1'b0);

    // timeout forces random move five cycles after entering WAIT
    for (int i = 3; i >= 0; i--) begin
      tick();
      check("rand_req_early", int'(rand_req_a), 0);
      check("tl_count", int'(tl_a), i);
    end
    tick();
    check("rand_req", int'(rand_req_a), 1);
    tick();
    check("rand_req_hold", int'(rand_req_a), 1);
    rand_done = 1'b1; tick(); rand_done = 1'b0;
    check("rand_req_drop", int'(rand_req_a), 0);
    check("rand_commit", int'(commit_a), 1);
    tick();
    check("rand_commit_once", int'(commit_a), 0);
    check("rand_mc", int'(mc_a), 5);
    win_done = 1'b1; tick(); win_done = 1'b0;
    tick();
    check("after5_a", int'(player_a), 2);
    check("after5_b", int'(player_b), 1);

    // fill the board without a winner
    do_move(1'b0, 1'b0); do_move(1'b0, 1'b0); do_move(1'b0, 1'b0); do_move(1'b0, 1'b1);
    check("tie_flag", int'(tie_a), 1);
    check("tie_over", int'(over_a), 1);
    check("tie_mc", int'(mc_a), 9);
    check("tie_player_a", int'(player_a), 2);
    check("tie_player_b", int'(player_b), 0);
    tick();
    check("done_hold_tie", int'(tie_a), 1);

    // restart from DONE, win on the fifth move
    start = 1'b1; tick(); start = 1'b0;
    check("restart_mc", int'(mc_a), 0);
    check("restart_tie", int'(tie_a), 0);
    check("restart_over", int'(over_a), 0);
    check("restart_player", int'(player_a), 0);
    do_move(1'b0, 1'b0); do_move(1'b0, 1'b0); do_move(1'b0, 1'b0); do_move(1'b0, 1'b0);
    do_move(1'b1, 1'b0);
    check("win_over", int'(over_b), 1);
    check("win_tie", int'(tie_b), 0);
    check("win_player_b", int'(player_b), 0);
    check("win_player_a", int'(player_a), 1);
    check("win_mc", int'(mc_b), 5);
    start = 1'b1; tick(); start = 1'b0;
    check("rewin_player", int'(player_b), 0);
    check("rewin_mc", int'(mc_b), 0);
    check("rewin_tie", int'(tie_b), 0);

    // reset mid-handshake with a late done
    move_ready = 1'b1; tick(); move_ready = 1'b0;
    check("mid_chk_req", int'(chk_req_a), 1);
    rst = 1'b1; tick(); rst = 1'b0;
    chk_done = 1'b1; chk_ok = 1'b1;
    check("mid_rst_chk_req", int'(chk_req_a), 0);
    check("mid_rst_tl", int'(tl_a), 0);
    tick(); chk_done = 1'b0; chk_ok = 1'b0;
    check("late_done_commit", int'(commit_a), 0);
    check("late_done_chk_req", int'(chk_req_a), 0);
    tick();
    check("late_done_commit2", int'(commit_a), 0);
    check("late_done_mc", int'(mc_a), 0);

    // move_ready beats timeout at time_left=0
    start = 1'b1; tick(); start = 1'b0;
    tick(); tick(); tick(); tick();
    check("prio_tl_zero", int'(tl_a), 0);
    move_ready = 1'b1; tick(); move_ready = 1'b0;
    check("prio_chk_req", int'(chk_req_a), 1);
    check("prio_rand_req", int'(rand_req_a), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
